axi_status_ctrl_regbank: RTL and testbench

Parametrised AXI4-Lite register bank for PVT, link and build status on the NTP server targets. It exposes N read-only status words, M read/write control registers with byte strobes and write pulses, and K saturating event counters with atomic snapshot/clear. It adds an ID word and SLVERR signalling for illegal accesses. It sits behind the PCIe AXI-Lite interconnect, one per target, in place of fixed-map status slaves.

---
 rtl/axi_regbank_pkg.sv | 27 ++
 rtl/evt_snap_counter.sv | 34 +++
 rtl/axi_status_ctrl_regbank.sv | 186 ++++++++++++++++++
 tb/tb_axi_status_ctrl_regbank.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_regbank_pkg.sv
// Shared constants and word-map helpers for the AXI-Lite status/control bank.
// Word offsets are derived from the status/control/event counts.
package axi_regbank_pkg;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] ID_DEFAULT  = 32'h11a6ebf8;

  function automatic int ctrl_base(input int ns);
    return ns;
  endfunction

  function automatic int evt_base(input int ns, input int nc);
    return ns + nc;
  endfunction

  function automatic int snap_idx(input int ns, input int nc,
                                  input int ne);
    return ns + nc + ne;
  endfunction

  function automatic int id_idx(input int ns, input int nc,
                                input int ne);
    return snap_idx(ns, nc, ne) + 1;
  endfunction

endpackage

// File: rtl/evt_snap_counter.sv
// One saturating event counter with a shadow copy.
// Ports: clk, rst_n, evt, snap, clr in; shadow out.
module evt_snap_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 evt,
  input  logic                 snap,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] shadow
);

  localparam logic [CNT_WIDTH-1:0] MAX = '1;

  logic [CNT_WIDTH-1:0] live;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live   <= '0;
      shadow <= '0;
    end else begin
      // snapshot sees the value before this cycle's event
      if (snap)
        shadow <= live;
      // a clear with a coincident event restarts at one
      if (clr)
        live <= CNT_WIDTH'(evt);
      else if (evt && live != MAX)
        live <= live + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/axi_status_ctrl_regbank.sv
// AXI4-Lite bank: RO status words, RW control regs, snapshot counters, ID.
// Ports: S_AXI_* slave channels, status_in, evt_in, ctrl_out, ctrl_wr_pulse.
module axi_status_ctrl_regbank
  import axi_regbank_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int NUM_STATUS = 13,
  parameter int NUM_CTRL   = 4,
  parameter int NUM_EVT    = 4,
  parameter int CNT_WIDTH  = 32,
  parameter logic [NUM_CTRL*32-1:0] CTRL_RESET = '0,
  parameter logic [31:0] ID_VALUE = ID_DEFAULT
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  input  logic [NUM_STATUS*32-1:0]      status_in,
  input  logic [NUM_EVT-1:0]            evt_in,
  output logic [NUM_CTRL*32-1:0]        ctrl_out,
  output logic [NUM_CTRL-1:0]           ctrl_wr_pulse
);

  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  localparam int S  = ctrl_base(NUM_STATUS);
  localparam int C  = evt_base(NUM_STATUS, NUM_CTRL);
  localparam int E  = snap_idx(NUM_STATUS, NUM_CTRL, NUM_EVT);
  localparam int ID = id_idx(NUM_STATUS, NUM_CTRL, NUM_EVT);

  if (E + 2 > (1 << IW)) begin : g_map_check
    $error("register map does not fit the address width");
  end

  wire clk   = S_AXI_ACLK;
  wire rst_n = S_AXI_ARESETN;

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  logic          aw_full, w_full, commit;
  logic [IW-1:0] aw_idx;
  logic [31:0]   w_data;
  logic [3:0]    w_strb;
  logic          is_ctrl, is_snap, snap, clr;

  assign commit  = aw_full && w_full;
  assign is_ctrl = aw_idx >= IW'(S) && aw_idx < IW'(C);
  assign is_snap = aw_idx == IW'(E);
  assign snap = commit && is_snap && w_strb[0] && w_data[0];
  assign clr  = commit && is_snap && w_strb[0] && w_data[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (S_AXI_AWREADY && S_AXI_AWVALID) begin
        S_AXI_AWREADY <= 1'b0;
        aw_full <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end else if (!aw_full && (!S_AXI_BVALID || S_AXI_BREADY)) begin
        S_AXI_AWREADY <= 1'b1;
      end
      if (S_AXI_WREADY && S_AXI_WVALID) begin
        S_AXI_WREADY <= 1'b0;
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end else if (!w_full && (!S_AXI_BVALID || S_AXI_BREADY)) begin
        S_AXI_WREADY <= 1'b1;
      end
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= (is_ctrl || is_snap) ? RESP_OKAY : RESP_SLVERR;
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  logic [31:0] ctrl_q [NUM_CTRL];
  logic [31:0] shd_w  [NUM_EVT];

  for (genvar k = 0; k < NUM_CTRL; k++) begin : g_ctrl
    wire hit = commit && aw_idx == IW'(S + k);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctrl_q[k] <= CTRL_RESET[k*32 +: 32];
        ctrl_wr_pulse[k] <= 1'b0;
      end else begin
        ctrl_wr_pulse[k] <= hit;
        for (int b = 0; b < 4; b++)
          if (hit && w_strb[b])
            ctrl_q[k][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
    assign ctrl_out[k*32 +: 32] = ctrl_q[k];
  end

  for (genvar k = 0; k < NUM_EVT; k++) begin : g_evt
    logic [CNT_WIDTH-1:0] shadow;
    evt_snap_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .evt    (evt_in[k]),
      .snap   (snap),
      .clr    (clr),
      .shadow (shadow)
    );
    assign shd_w[k] = 32'(shadow);
  end

  logic [IW-1:0] ar_idx;
  logic [31:0]   rd_data;
  logic          rd_err;

  assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (ar_idx < IW'(S)) begin
      for (int k = 0; k < NUM_STATUS; k++)
        if (ar_idx == IW'(k)) rd_data = status_in[k*32 +: 32];
    end else if (ar_idx < IW'(C)) begin
      for (int k = 0; k < NUM_CTRL; k++)
        if (ar_idx == IW'(S + k)) rd_data = ctrl_q[k];
    end else if (ar_idx < IW'(E)) begin
      for (int k = 0; k < NUM_EVT; k++)
        if (ar_idx == IW'(C + k)) rd_data = shd_w[k];
    end else if (ar_idx == IW'(ID)) begin
      rd_data = ID_VALUE;
    end else if (ar_idx != IW'(E)) begin
      rd_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      if (S_AXI_ARREADY && S_AXI_ARVALID) begin
        S_AXI_ARREADY <= 1'b0;
        S_AXI_RVALID  <= 1'b1;
        S_AXI_RDATA   <= rd_data;
        S_AXI_RRESP   <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else begin
        if (!S_AXI_RVALID || S_AXI_RREADY)
          S_AXI_ARREADY <= 1'b1;
        if (S_AXI_RVALID && S_AXI_RREADY)
          S_AXI_RVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_status_ctrl_regbank.sv
// Directed bench for axi_status_ctrl_regbank with a behavioural map model.
// Counters are 4 bits wide so saturation is reachable quickly.
module tb_axi_status_ctrl_regbank;

  localparam int NS = 13, NC = 4, NE = 4, MAXC = 15;
  localparam logic [NC*32-1:0] CRST =
    {32'h44556677, 32'h0, 32'hA5A5A5A5, 32'h11223344};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]    S_AXI_AWPROT, S_AXI_ARPROT;
  logic          S_AXI_AWVALID, S_AXI_AWREADY;
  logic [31:0]   S_AXI_WDATA;
  logic [3:0]    S_AXI_WSTRB;
  logic          S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID, S_AXI_BREADY;
  logic          S_AXI_ARVALID, S_AXI_ARREADY;
  logic [31:0]   S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID, S_AXI_RREADY;
  logic [NS*32-1:0] status_in;
  logic [NE-1:0] evt_in;
  logic [NC*32-1:0] ctrl_out;
  logic [NC-1:0] ctrl_wr_pulse;

  always #5 clk = ~clk;

  axi_status_ctrl_regbank #(
    .CNT_WIDTH  (4),
    .CTRL_RESET (CRST)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .status_in     (status_in),
    .evt_in        (evt_in),
    .ctrl_out      (ctrl_out),
    .ctrl_wr_pulse (ctrl_wr_pulse)
  );

  int n_vec = 0, n_err = 0, n_wr = 0, n_brise = 0;
  logic run = 1'b0;

  logic [31:0] m_ctrl [NC];
  int m_live [NE];
  int m_live_b [NE];
  int m_shadow [NE];
  logic [NE-1:0] evt_last;
  logic [7:0]  cur_addr;
  logic [31:0] cur_data;
  logic [3:0]  cur_strb;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timeout at %0t", nm, $time);
  endtask

  function automatic logic [1:0] exp_bresp(input logic [7:0] a);
    int w;
    w = int'(a[7:2]);
    return ((w >= 13 && w < 17) || w == 21) ? 2'b00 : 2'b10;
  endfunction

  task automatic model_read(input logic [7:0] a, output logic [31:0] d,
                            output logic [1:0] r);
    int w;
    w = int'(a[7:2]);
    d = 32'h0;
    r = 2'b00;
    if (w < 13) d = 32'hC0DE0000 + 32'(w);
    else if (w < 17) d = m_ctrl[w-13];
    else if (w < 21) d = 32'(m_shadow[w-17]);
    else if (w == 22) d = 32'h11a6ebf8;
    else if (w > 22) r = 2'b10;
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly,
                           input int b_dly);
    int n;
    cur_addr = addr;
    cur_data = data;
    cur_strb = strb;
    n_wr++;
    fork
      begin : wch
        int t;
        S_AXI_WDATA = data;
        S_AXI_WSTRB = strb;
        S_AXI_WVALID = 1'b1;
        t = 0;
        @(negedge clk);
        while (!S_AXI_WREADY && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) tmo("w_handshake");
        @(posedge clk); #1 S_AXI_WVALID = 1'b0;
      end
      begin : awch
        int t;
        if (aw_dly > 0) begin repeat (aw_dly) @(posedge clk); #1; end
        S_AXI_AWADDR = addr;
        S_AXI_AWVALID = 1'b1;
        t = 0;
        @(negedge clk);
        while (!S_AXI_AWREADY && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) tmo("aw_handshake");
        @(posedge clk); #1 S_AXI_AWVALID = 1'b0;
      end
    join
    if (b_dly > 0) begin repeat (b_dly) @(posedge clk); #1; end
    S_AXI_BREADY = 1'b1;
    n = 0;
    @(negedge clk);
    while (!S_AXI_BVALID && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) tmo("b_wait");
    chk("bresp", 32'(S_AXI_BRESP), 32'(exp_bresp(addr)));
    @(posedge clk); #1 S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] d);
    logic [31:0] ed;
    logic [1:0]  er;
    int n;
    model_read(addr, ed, er);
    S_AXI_ARADDR = addr;
    S_AXI_ARVALID = 1'b1;
    n = 0;
    @(negedge clk);
    while (!S_AXI_ARREADY && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) tmo("ar_handshake");
    @(posedge clk); #1 S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b1;
    n = 0;
    @(negedge clk);
    while (!S_AXI_RVALID && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) tmo("r_wait");
    d = S_AXI_RDATA;
    chk("rdata", S_AXI_RDATA, ed);
    chk("rresp", 32'(S_AXI_RRESP), 32'(er));
    @(posedge clk); #1 S_AXI_RREADY = 1'b0;
  endtask

  task automatic pulse_evt(input int idx, input int n);
    for (int i = 0; i < n; i++) begin
      evt_in[idx] = 1'b1;
      @(posedge clk); #1;
    end
    evt_in[idx] = 1'b0;
  endtask

  // Per-cycle compare of control outputs, pulses and B stability.
  initial begin : cmp
    logic prev_bv, prev_br, brose;
    logic [1:0] prev_bresp;
    logic [NC-1:0] pexp;
    int w;
    prev_bv = 1'b0;
    prev_br = 1'b0;
    prev_bresp = 2'b00;
    forever begin
      @(negedge clk);
      if (run) begin
        brose = S_AXI_BVALID && !prev_bv;
        pexp = '0;
        if (brose) begin
          n_brise++;
          w = int'(cur_addr[7:2]);
          if (w >= 13 && w < 17) begin
            for (int b = 0; b < 4; b++)
              if (cur_strb[b])
                m_ctrl[w-13][8*b +: 8] = cur_data[8*b +: 8];
            pexp[w-13] = 1'b1;
          end
          if (w == 21 && cur_strb[0]) begin
            for (int k = 0; k < NE; k++) begin
              if (cur_data[0]) m_shadow[k] = m_live_b[k];
              if (cur_data[1]) m_live[k] = evt_last[k] ? 1 : 0;
            end
          end
        end
        if (prev_bv && !prev_br) begin
          chk("b_hold", 32'(S_AXI_BVALID), 32'd1);
          chk("bresp_hold", 32'(S_AXI_BRESP), 32'(prev_bresp));
        end
        for (int k = 0; k < NC; k++)
          chk($sformatf("ctrl_out%0d", k), ctrl_out[k*32 +: 32], m_ctrl[k]);
        chk("wr_pulse", 32'(ctrl_wr_pulse), 32'(pexp));
        for (int k = 0; k < NE; k++) begin
          m_live_b[k] = m_live[k];
          if (evt_in[k] && m_live[k] < MAXC) m_live[k]++;
        end
        evt_last = evt_in;
        prev_bv = S_AXI_BVALID;
        prev_br = S_AXI_BREADY;
        prev_bresp = S_AXI_BRESP;
      end
    end
  end

  initial begin : wdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] d;
    rst_n = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_ARADDR = '0;
    S_AXI_AWPROT = '0; S_AXI_ARPROT = '0;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
    S_AXI_BREADY = 0; S_AXI_RREADY = 0;
    evt_in = '0;
    for (int k = 0; k < NS; k++)
      status_in[k*32 +: 32] = 32'hC0DE0000 + 32'(k);
    for (int k = 0; k < NC; k++) m_ctrl[k] = CRST[k*32 +: 32];
    for (int k = 0; k < NE; k++) begin
      m_live[k] = 0; m_live_b[k] = 0; m_shadow[k] = 0;
    end
    evt_last = '0;

    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd0);
    chk("rst_valid", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'd0);
    chk("rst_resp", 32'({S_AXI_BRESP, S_AXI_RRESP}), 32'd0);
    chk("rst_rdata", S_AXI_RDATA, 32'd0);
    chk("rst_ctrl0", ctrl_out[31:0], 32'h11223344);
    chk("rst_pulse", 32'(ctrl_wr_pulse), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run = 1'b1;
    @(negedge clk);
    chk("rdy_pre_edge", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}),
        32'd0);
    @(negedge clk);
    chk("rdy_after_edge", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}),
        32'd7);
    @(posedge clk); #1;

    axi_write(8'h34, 32'hAABBCCDD, 4'b0101, 0, 0);
    chk("strb_lit", ctrl_out[31:0], 32'h11BB33DD);
    axi_read(8'h34, d);

    axi_write(8'h3C, 32'h5A5A1234, 4'hF, 3, 5);
    axi_read(8'h3C, d);
    chk("order_lit", d, 32'h5A5A1234);

    axi_write(8'h00, 32'hFFFFFFFF, 4'hF, 0, 0);
    axi_write(8'h58, 32'h12345678, 4'hF, 0, 1);
    axi_write(8'h44, 32'h00000007, 4'hF, 1, 0);
    axi_write(8'hFC, 32'hDEADBEEF, 4'hF, 0, 0);
    axi_read(8'h00, d);
    chk("status0_lit", d, 32'hC0DE0000);

    pulse_evt(1, 10);
    fork
      axi_write(8'h54, 32'h3, 4'hF, 0, 0);
      begin
        @(posedge clk); #1 evt_in[1] = 1'b1;
        @(posedge clk); #1 evt_in[1] = 1'b0;
      end
    join
    axi_read(8'h48, d);
    chk("snap10_lit", d, 32'd10);
    axi_write(8'h54, 32'h1, 4'hF, 0, 0);
    axi_read(8'h48, d);
    chk("snap1_lit", d, 32'd1);

    pulse_evt(2, 20);
    axi_write(8'h54, 32'h1, 4'hF, 0, 0);
    axi_read(8'h4C, d);
    chk("sat_lit", d, 32'h0000000F);
    axi_write(8'h54, 32'h3, 4'b1110, 0, 0);
    axi_write(8'h54, 32'h1, 4'hF, 0, 0);
    axi_read(8'h4C, d);
    chk("nostrb_lit", d, 32'h0000000F);
    axi_write(8'h54, 32'h2, 4'hF, 0, 0);
    axi_write(8'h54, 32'h1, 4'hF, 0, 0);
    axi_read(8'h4C, d);
    chk("clr_lit", d, 32'd0);

    axi_read(8'h54, d);
    axi_read(8'h58, d);
    chk("id_lit", d, 32'h11a6ebf8);
    axi_read(8'h5C, d);
    chk("unmapped_lit", d, 32'd0);
    axi_read(8'hFC, d);
    axi_read(8'h14, d);
    chk("status5_lit", d, 32'hC0DE0005);

    repeat (4) @(posedge clk);
    chk("b_count", 32'(n_brise), 32'(n_wr));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
